mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sequences the single byte-wide RAM port shared by instruction fetch (IF) and the MEM stage.
- Turns 32-bit fetches and 1/2/4-byte loads/stores into multi-cycle little-endian byte transactions.
- Generates stl_mm, which freezes the pipeline registers while a MEM access is outstanding.
- Sits between the IF/MEM stages and the RAM.

Parameters:
- RAM_RD_LAT, 1, cycles from ram_addr presented to ram_din valid (supported values: 1 or 2).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- if_req  in  1  IF wants a 32-bit fetch; held until if_done or if_cancel.
- if_addr  in  32  fetch address; stable while if_req is high.
- if_cancel  in  1  branch/jump redirect: abort the in-flight fetch.
- if_done  out  1  one-cycle pulse; if_data valid.
- if_data  out  32  fetched word.
- mm_req  in  1  MEM stage access request; held until mm_done.
- mm_wr  in  1  1 = store, 0 = load.
- mm_len  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- mm_addr  in  32  access base address.
- mm_wdata  in  32  store data; low bytes used.
- mm_done  out  1  one-cycle pulse.
- mm_rdata  out  32  load data, zero-extended (the MEM stage sign-extends).
- stl_mm  out  1  pipeline stall.
- ram_addr  out  32  RAM byte address.
- ram_dout  out  8  RAM write byte.
- ram_wr  out  1  RAM write enable.
- ram_din  in  8  RAM read byte.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; all outputs are 0, including ram_wr, ram_addr, if_data and mm_rdata.
  - Reset mid-transaction aborts it with no done pulse and no further RAM writes.
- FSM states: IDLE, FETCH, DATA.
  - IDLE → DATA if mm_req (MEM has priority, being the older instruction).
  - IDLE → FETCH if if_req && !if_cancel.
  - Otherwise stay in IDLE.
  - On completion, return to IDLE. A new request is sampled the cycle after the done pulse; there is no back-to-back chaining.
- Byte counter cnt, 0..N-1, where N = 4 for a fetch and N = 1/2/4 for a MEM access:
  - ram_addr = base + cnt, modulo 2^32; wrap-around is allowed.
- Reads (FETCH, or DATA with mm_wr = 0):
  - Addresses are issued in N consecutive cycles.
  - The byte for cnt = k is captured RAM_RD_LAT cycles later into bits [8k+7:8k].
  - The done pulse is registered in the cycle after the last byte is captured.
  - Word-read latency, request-sample to done = N + RAM_RD_LAT + 1 cycles (6 at defaults).
- Writes (DATA with mm_wr = 1):
  - ram_wr = 1 for N consecutive cycles, with ram_dout = mm_wdata[8cnt+7:8cnt].
  - mm_done pulses the cycle after the last write byte. Latency is N + 1.
- stl_mm:
  - Combinational: mm_req && !mm_done.
  - It is therefore high while MEM waits in IDLE behind an active fetch, and while DATA runs.
  - It drops in the mm_done cycle so the pipeline advances exactly once.
- if_cancel:
  - In FETCH: the fetch aborts, the next state is IDLE, and no if_done is issued.
  - Stale read bytes still in the RAM pipe are discarded.
  - In the same cycle as if_done: the done pulse is suppressed.
  - In IDLE or DATA: ignored.
- Outputs outside the done pulse:
  - if_data and mm_rdata hold their last values.
  - ram_dout is 0 whenever ram_wr = 0.
- mm_req is never preempted. A fetch already in FETCH is never preempted by mm_req; MEM waits with stl_mm high.

Optional Feature:
- Macro: MEM_ARB_FETCH_BUF_EN.
- Defined:
  - Adds a one-entry fetch buffer holding {valid, addr, word} from the last completed fetch.
  - In IDLE, if_req with if_addr == buffer addr and valid set (and no mm_req) answers with if_done the next cycle, without a RAM access.
  - Any store (mm_wr = 1) clears valid when it starts DATA.
  - if_cancel does not clear the buffer.
  - Reset clears valid.
- Undefined: every fetch goes to RAM; no buffer registers exist.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE/FETCH/DATA);
  - mm_len codes (LEN_B = 0, LEN_H = 1, LEN_W = 2);
  - a len→byte-count function;
  - the default RAM_RD_LAT.
- Sub-module mem_byte_seq:
  - contains the counter, address generation and read-data assembly with its RAM_RD_LAT delay line;
  - takes start/base/nbytes/wr/wdata/abort;
  - returns busy/done/rdata and the RAM port signals.
- mem_arbiter keeps the FSM, arbitration, stl_mm and the optional buffer.

Test Plan:
- Fetch: if_req, addr 0x100, RAM bytes 0x13,0x05,0x10,0x00 → ram_addr 0x100..0x103; if_done 6 cycles after request with if_data = 0x00100513.
- Priority: if_req and mm_req (load word, 0x2000) both rise in IDLE → DATA first; stl_mm high until mm_done; then FETCH runs; if_done follows.
- Store half: mm_wr = 1, len = 1, addr 0x3001, wdata 0xAABBCCDD → ram_wr cycles write 0xDD@0x3001 and 0xCC@0x3002; mm_done 3 cycles after start; no third write.
- Cancel: if_cancel two cycles into a fetch at 0x200 → no if_done; IDLE next cycle; a following fetch at 0x300 returns correct data, uncorrupted by stale bytes.
- Wrap and reset: word load at 0xFFFFFFFE → bytes from 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1. Separately, assert rst low mid-store → ram_wr drops immediately; no mm_done; stl_mm = 0 while mm_req = 0.
- MEM_ARB_FETCH_BUF_EN: repeat fetch of 0x100 → if_done 1 cycle later with no ram_addr activity. After a store to 0x500, a fetch of 0x100 goes to RAM again.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the byte-wide RAM port arbiter.
package mem_arb_pkg;

    localparam int unsigned RAM_RD_LAT_DEF = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    // Access length code to byte count; code 3 behaves as a word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer: issues N little-endian byte addresses/writes and assembles
// read bytes arriving RAM_RD_LAT cycles after their address.
module mem_byte_seq
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned RAM_RD_LAT = RAM_RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [2:0]        nbytes,
    input  logic              wr,
    input  logic [31:0]       wdata,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              last_c,
    output logic [31:0]       word_c,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din
);

    localparam int unsigned LT = RAM_RD_LAT - 1;

    logic              issuing;
    logic [1:0]        cnt;
    logic [1:0]        last_idx;
    logic              wr_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q;
    logic [RAM_RD_LAT-1:0] vld;
    logic [RAM_RD_LAT-1:0] tag_lst;
    logic [1:0]        tag_idx [RAM_RD_LAT];
    logic [1:0]        cnt_nxt;
    logic              at_last;

    assign cnt_nxt = cnt + 2'd1;
    assign at_last = (cnt == last_idx);
    assign busy    = issuing || (|vld);

    // Assembled word including the byte arriving this cycle.
    always_comb begin
        word_c = asm_q;
        if (vld[LT]) word_c[{tag_idx[LT], 3'b000} +: 8] = ram_din;
        last_c = vld[LT] && tag_lst[LT];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issuing  <= 1'b0;
            cnt      <= '0;
            last_idx <= '0;
            wr_q     <= 1'b0;
            base_q   <= '0;
            wdata_q  <= '0;
            asm_q    <= '0;
            done     <= 1'b0;
            ram_addr <= '0;
            ram_dout <= '0;
            ram_wr   <= 1'b0;
            vld      <= '0;
            tag_lst  <= '0;
            for (int unsigned i = 0; i < RAM_RD_LAT; i++) tag_idx[i] <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Dropping the valid tags discards bytes still in the RAM pipe.
                issuing  <= 1'b0;
                ram_addr <= '0;
                ram_dout <= '0;
                ram_wr   <= 1'b0;
                vld      <= '0;
            end else begin
                if (start) begin
                    issuing  <= 1'b1;
                    cnt      <= '0;
                    last_idx <= 2'(nbytes - 3'd1);
                    wr_q     <= wr;
                    base_q   <= base;
                    wdata_q  <= wdata;
                    asm_q    <= '0;
                    ram_addr <= base;
                    ram_wr   <= wr;
                    ram_dout <= wr ? wdata[7:0] : 8'h00;
                end else if (issuing) begin
                    if (at_last) begin
                        issuing  <= 1'b0;
                        ram_addr <= '0;
                        ram_wr   <= 1'b0;
                        ram_dout <= '0;
                        done     <= wr_q;
                    end else begin
                        cnt      <= cnt_nxt;
                        ram_addr <= base_q + ADDR_W'(cnt_nxt);
                        ram_dout <= wr_q ? 8'(wdata_q >> {cnt_nxt, 3'b000}) : 8'h00;
                    end
                end
                vld[0]     <= issuing && !wr_q;
                tag_lst[0] <= at_last;
                tag_idx[0] <= cnt;
                for (int unsigned i = 1; i < RAM_RD_LAT; i++) begin
                    vld[i]     <= vld[i-1];
                    tag_lst[i] <= tag_lst[i-1];
                    tag_idx[i] <= tag_idx[i-1];
                end
                if (vld[LT]) begin
                    asm_q <= word_c;
                    if (tag_lst[LT]) done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the byte-wide RAM port between IF fetches and MEM accesses.
// Optional one-entry fetch buffer enabled by `define MEM_ARB_FETCH_BUF_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned RAM_RD_LAT = RAM_RD_LAT_DEF,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mm_req,
    input  logic              mm_wr,
    input  logic [1:0]        mm_len,
    input  logic [ADDR_W-1:0] mm_addr,
    input  logic [31:0]       mm_wdata,
    output logic              mm_done,
    output logic [31:0]       mm_rdata,
    output logic              stl_mm,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din
);

    state_t            state, state_nxt;
    logic              seq_start, seq_abort, seq_wr;
    logic [ADDR_W-1:0] seq_base;
    logic [2:0]        seq_nbytes;
    logic              seq_busy, seq_done, seq_last;
    logic [31:0]       seq_word;
    logic              hold, buf_hit;

`ifdef MEM_ARB_FETCH_BUF_EN
    logic              buf_valid, hit_q, buf_take;
    logic [ADDR_W-1:0] buf_addr;
    logic [31:0]       buf_word;
    assign hold     = hit_q;
    assign buf_hit  = buf_valid && (if_addr == buf_addr);
    assign buf_take = (state == IDLE) && !hold && !seq_busy && !mm_req &&
                      if_req && !if_cancel && buf_hit;
`else
    assign hold    = 1'b0;
    assign buf_hit = 1'b0;
`endif

    mem_byte_seq #(.ADDR_W(ADDR_W), .RAM_RD_LAT(RAM_RD_LAT)) u_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (seq_start),
        .base     (seq_base),
        .nbytes   (seq_nbytes),
        .wr       (seq_wr),
        .wdata    (mm_wdata),
        .abort    (seq_abort),
        .busy     (seq_busy),
        .done     (seq_done),
        .last_c   (seq_last),
        .word_c   (seq_word),
        .ram_addr (ram_addr),
        .ram_dout (ram_dout),
        .ram_wr   (ram_wr),
        .ram_din  (ram_din)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // MEM wins in IDLE; an accepted fetch runs to completion or cancel.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!hold && !seq_busy) begin
                    if (mm_req)                               state_nxt = DATA;
                    else if (if_req && !if_cancel && !buf_hit) state_nxt = FETCH;
                end
            end
            FETCH:   if (if_cancel || seq_done) state_nxt = IDLE;
            DATA:    if (seq_done)              state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        seq_start  = 1'b0;
        seq_abort  = 1'b0;
        seq_base   = if_addr;
        seq_nbytes = 3'd4;
        seq_wr     = 1'b0;
        if (state == IDLE && state_nxt == DATA) begin
            seq_start  = 1'b1;
            seq_base   = mm_addr;
            seq_nbytes = len_bytes(mm_len);
            seq_wr     = mm_wr;
        end else if (state == IDLE && state_nxt == FETCH) begin
            seq_start = 1'b1;
        end
        if (state == FETCH && if_cancel) seq_abort = 1'b1;
`ifdef MEM_ARB_FETCH_BUF_EN
        if_done = ((state == FETCH && seq_done) || hit_q) && !if_cancel;
`else
        if_done = (state == FETCH) && seq_done && !if_cancel;
`endif
        mm_done = (state == DATA) && seq_done;
        stl_mm  = mm_req && !mm_done;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_data  <= '0;
            mm_rdata <= '0;
        end else begin
            if (state == FETCH && seq_last && !if_cancel) if_data <= seq_word;
`ifdef MEM_ARB_FETCH_BUF_EN
            else if (buf_take) if_data <= buf_word;
`endif
            if (state == DATA && seq_last) mm_rdata <= seq_word;
        end
    end

`ifdef MEM_ARB_FETCH_BUF_EN
    // Remembers the last completed fetch; any store invalidates it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_word  <= '0;
            hit_q     <= 1'b0;
        end else begin
            hit_q <= buf_take;
            if (seq_start && seq_wr) begin
                buf_valid <= 1'b0;
            end else if (state == FETCH && seq_done && !if_cancel) begin
                buf_valid <= 1'b1;
                buf_addr  <= if_addr;
                buf_word  <= if_data;
            end
        end
    end
`endif

endmodule
